ping_pong_ctrl: RTL
===================

# ping_pong_ctrl

Controller that sequences an external two-bank ping-pong buffer, one simple dual-port RAM of 2×DEPTH words with the bank selected by the address MSB. The producer fills one bank while the consumer drains the other; banks swap when a bank is completed (last address written, or explicit flush) and when a bank is fully drained. It generates all RAM write/read controls and per-bank status, and sits between the stream producer, the buffer RAM and the stream consumer.

## Interface
- `ADDR_W`, 7 — bank address width; DEPTH = 2^ADDR_W words per bank
- `DATA_W`, 8 — data word width
- `sys_clk` in 1 — single clock; all logic is on the rising edge
- `sys_rst_n` in 1 — asynchronous active-low reset
- `wr_en` in 1 — producer write request
- `wr_data` in DATA_W — producer data
- `wr_flush` in 1 — commit the partially filled write bank
- `wr_ready` out 1 — write bank can accept a word (combinational)
- `wr_drop` out 1 — one-cycle pulse: `wr_en` seen while `wr_ready`=0; the word is discarded
- `rd_en` in 1 — consumer read request
- `rd_avail` out 1 — read bank holds committed data (combinational)
- `rd_valid` out 1 — RAM read data is valid this cycle
- `rd_last` out 1 — qualifies `rd_valid`: last word of the bank
- `mem_wr_en` out 1, `mem_wr_addr` out ADDR_W+1, `mem_wr_data` out DATA_W — RAM write port (registered)
- `mem_rd_en` out 1, `mem_rd_addr` out ADDR_W+1 — RAM read port (registered); RAM read latency is 1 cycle
- `bank_full` out 2 — bit b = bank b committed and not yet drained
- `wr_bank`, `rd_bank` out 1 each — current write and read bank

## Operation
- State: `wr_bank`, `wr_ptr` (ADDR_W), `rd_bank`, `rd_ptr` (ADDR_W), `bank_full[1:0]`, and `bank_len[b]` (ADDR_W+1 bits, range 1..DEPTH).
- `wr_ready` = !bank_full[wr_bank]; `rd_avail` = bank_full[rd_bank].
- Accepted write (`wr_en` && `wr_ready`):
  - `mem_wr_addr` ← {wr_bank, wr_ptr}.
  - `wr_ptr` increments.
  - When `wr_ptr` = DEPTH-1: `bank_len[wr_bank]` ← DEPTH, set `bank_full[wr_bank]`, toggle `wr_bank`, `wr_ptr` ← 0.
- Flush (`wr_flush` && `wr_ready`): the committed count n = wr_ptr + (1 if a write is accepted in the same cycle).
  - If n = 0, flush is ignored.
  - Otherwise: `bank_len` ← n, set full, toggle `wr_bank`, `wr_ptr` ← 0.
  - When n = DEPTH, the result is identical to a normal bank completion.
  - A flush while `wr_ready`=0 is ignored.
- Accepted read (`rd_en` && `rd_avail`):
  - `mem_rd_addr` ← {rd_bank, rd_ptr}.
  - When `rd_ptr` = bank_len[rd_bank]-1: clear `bank_full[rd_bank]`, toggle `rd_bank`, `rd_ptr` ← 0, and tag the access as last.
  - Otherwise `rd_ptr` increments.
  - `rd_en` while `rd_avail`=0 is ignored; no error flag.
- Same-cycle set and clear always target different banks: set requires !full and clear requires full. Both updates apply.
- Order: the producer and consumer alternate banks 0,1,0,1…; data leaves in the order it was written.
- Reset (asynchronous, any time): all pointers, banks and `bank_full` go to 0; all outputs go to 0. Buffered data is abandoned.

## Timing
- Accept at edge k:
  - `mem_wr_en`, address and data are high/valid after edge k; the RAM writes at edge k+1.
  - `bank_full`, `wr_bank` and `wr_ready` update after edge k.
- Earliest read of a just-committed bank: `rd_en` accepted at edge k+1. `mem_rd_en` is high after edge k+1, and the RAM samples at edge k+2, after the write completed.
- `rd_valid`/`rd_last` = `mem_rd_en`/last-tag delayed 1 cycle. Total read latency is 2 cycles from the `rd_en` accept edge.
- `wr_drop` is registered: it pulses the cycle after the refused request.
- Sustained throughput is 1 word/cycle on each side when both banks are cycling.

## Test plan
- Reset, then DEPTH=128 writes of 0..127 with no reads:
  - bank_full=01, wr_bank=1.
  - Then reads: 128 `rd_valid` beats with data 0..127, `rd_last` on the 128th, bank_full=00.
- Writes continue with no reads:
  - After 256 accepted writes, `wr_ready`=0.
  - The 257th `wr_en` gives a `wr_drop` pulse; the RAM is not written and bank_full=11.
- Write 5 words, then `wr_flush`:
  - bank_len=5 and the bank is full.
  - Reads return 5 beats, `rd_last` on the 5th, rd_bank toggles.
  - A flush with wr_ptr=0 and no write changes nothing.
- Flush in the same cycle as the 3rd write: bank_len=3, and the 3rd word is read back.
- Continuous writes and continuous `rd_en` for 1024 cycles:
  - No drops.
  - Read data equals the write sequence.
  - First `rd_valid` appears 2 cycles after bank 0 commits.
- Assert `sys_rst_n` low mid-drain: all outputs go to 0 immediately. After release, `wr_ready`=1 and `rd_avail`=0.

Source files
------------

// File: rtl/ping_pong_ctrl.sv
// ping_pong_ctrl
//   Sequences a two-bank ping-pong buffer held in one simple dual-port RAM of
//   2*DEPTH words. The bank is selected by the RAM address MSB. The producer
//   fills the write bank while the consumer drains the read bank. Banks are
//   handed over on completion (last address or flush) and on full drain.
//
// Ports
//   sys_clk, sys_rst_n        clock, async active-low reset
//   wr_en/wr_data/wr_flush    producer request, data, commit of partial bank
//   wr_ready, wr_drop         write bank can accept / refused-request pulse
//   rd_en                     consumer read request
//   rd_avail                  read bank holds committed data
//   rd_valid, rd_last         RAM read data valid / last word of the bank
//   mem_wr_*                  registered RAM write port
//   mem_rd_en, mem_rd_addr    registered RAM read port (1-cycle RAM latency)
//   bank_full, wr_bank, rd_bank  per-bank status and current bank selects
module ping_pong_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_flush,
    output logic              wr_ready,
    output logic              wr_drop,
    input  logic              rd_en,
    output logic              rd_avail,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              mem_wr_en,
    output logic [ADDR_W:0]   mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_rd_en,
    output logic [ADDR_W:0]   mem_rd_addr,
    output logic [1:0]        bank_full,
    output logic              wr_bank,
    output logic              rd_bank
);

    logic              r_wr_bank;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic              r_rd_bank;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [1:0]        r_bank_full;
    logic [ADDR_W:0]   r_bank_len [2];
    logic              r_rd_last_tag;

    logic              w_wr_ready;
    logic              w_rd_avail;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W:0]   w_wr_cnt;
    logic              w_wr_commit;
    logic              w_rd_done;
    logic [1:0]        w_bank_full_nxt;

    // Qualified by reset so every output reads 0 while reset is asserted.
    assign w_wr_ready = sys_rst_n & ~r_bank_full[r_wr_bank];
    assign w_rd_avail = sys_rst_n &  r_bank_full[r_rd_bank];

    assign w_wr_acc = wr_en & w_wr_ready;
    assign w_rd_acc = rd_en & w_rd_avail;

    // Words committed if the bank closes this cycle; reaches DEPTH when the
    // last address is written, which makes a full-bank flush identical to a
    // normal completion.
    assign w_wr_cnt    = {1'b0, r_wr_ptr} + {{ADDR_W{1'b0}}, w_wr_acc};
    assign w_wr_commit = w_wr_ready &
                         ((w_wr_acc & (&r_wr_ptr)) |
                          (wr_flush & (w_wr_cnt != '0)));

    assign w_rd_done = ({1'b0, r_rd_ptr} ==
                        (r_bank_len[r_rd_bank] - {{ADDR_W{1'b0}}, 1'b1}));

    // Set and clear can never hit the same bank: set needs !full, clear
    // needs full.
    always_comb begin
        w_bank_full_nxt = r_bank_full;
        if (w_wr_commit)
            w_bank_full_nxt[r_wr_bank] = 1'b1;
        if (w_rd_acc && w_rd_done)
            w_bank_full_nxt[r_rd_bank] = 1'b0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_bank     <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_bank     <= 1'b0;
            r_rd_ptr      <= '0;
            r_bank_full   <= '0;
            r_bank_len[0] <= '0;
            r_bank_len[1] <= '0;
        end else begin
            r_bank_full <= w_bank_full_nxt;
            if (w_wr_commit) begin
                r_bank_len[r_wr_bank] <= w_wr_cnt;
                r_wr_bank             <= ~r_wr_bank;
                r_wr_ptr              <= '0;
            end else if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                if (w_rd_done) begin
                    r_rd_bank <= ~r_rd_bank;
                    r_rd_ptr  <= '0;
                end else begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mem_wr_en     <= 1'b0;
            mem_wr_addr   <= '0;
            mem_wr_data   <= '0;
            wr_drop       <= 1'b0;
            mem_rd_en     <= 1'b0;
            mem_rd_addr   <= '0;
            r_rd_last_tag <= 1'b0;
            rd_valid      <= 1'b0;
            rd_last       <= 1'b0;
        end else begin
            mem_wr_en     <= w_wr_acc;
            wr_drop       <= wr_en & ~w_wr_ready;
            if (w_wr_acc) begin
                mem_wr_addr <= {r_wr_bank, r_wr_ptr};
                mem_wr_data <= wr_data;
            end
            mem_rd_en     <= w_rd_acc;
            if (w_rd_acc)
                mem_rd_addr <= {r_rd_bank, r_rd_ptr};
            r_rd_last_tag <= w_rd_acc & w_rd_done;
            // RAM data arrives one cycle after the read strobe.
            rd_valid      <= mem_rd_en;
            rd_last       <= r_rd_last_tag;
        end
    end

    assign wr_ready  = w_wr_ready;
    assign rd_avail  = w_rd_avail;
    assign bank_full = r_bank_full;
    assign wr_bank   = r_wr_bank;
    assign rd_bank   = r_rd_bank;

endmodule
